// File: rtl/hpm_counter_bank_pkg.sv
// Shared definitions for the HPM counter bank: register map constants and event indices.
// Event index k selects events_i[k-1]; index 0 means "count nothing".
package hpm_counter_bank_pkg;

  localparam logic [5:0] HPM_CNT_BASE = 6'd0;
  localparam logic [5:0] HPM_SEL_BASE = 6'd32;
  localparam logic [5:0] HPM_OVF_ADDR = 6'd62;
  localparam logic [5:0] HPM_INH_ADDR = 6'd63;

  typedef enum logic [7:0] {
    HPM_EV_NONE           = 8'd0,
    HPM_EV_ICACHE_MISS    = 8'd1,
    HPM_EV_DCACHE_MISS    = 8'd2,
    HPM_EV_ITLB_MISS      = 8'd3,
    HPM_EV_DTLB_MISS      = 8'd4,
    HPM_EV_LOAD           = 8'd5,
    HPM_EV_STORE          = 8'd6,
    HPM_EV_BRANCH         = 8'd7,
    HPM_EV_CALL           = 8'd8,
    HPM_EV_RET            = 8'd9,
    HPM_EV_EXCEPTION      = 8'd10,
    HPM_EV_ERET           = 8'd11,
    HPM_EV_MISPREDICT     = 8'd12,
    HPM_EV_SB_FULL        = 8'd13,
    HPM_EV_IF_EMPTY       = 8'd14,
    HPM_EV_IPREFETCH_MISS = 8'd15,
    HPM_EV_IPREFETCH_HIT  = 8'd16
  } hpm_event_e;

endpackage

// File: rtl/hpm_counter.sv
// One performance counter with its event selector. A software write to the counter
// takes priority over that cycle's increment; ovf_pulse flags an increment that wraps.
module hpm_counter
  import hpm_counter_bank_pkg::*;
#(
  parameter int unsigned NUM_EVENTS = 32,
  parameter int unsigned CNT_WIDTH  = 48,
  parameter int unsigned SEL_W      = $clog2(NUM_EVENTS + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_EVENTS-1:0] evt_q,
  input  logic                  inhibit,
  input  logic                  debug,
  input  logic                  cnt_we,
  input  logic                  sel_we,
  input  logic [CNT_WIDTH-1:0]  cnt_wdata,
  input  logic [SEL_W-1:0]      sel_wdata,
  output logic [CNT_WIDTH-1:0]  count,
  output logic [SEL_W-1:0]      sel,
  output logic                  ovf_pulse
);

  logic hit;
  logic inc;

  // Selector values outside 1..NUM_EVENTS never match, so they count nothing.
  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < NUM_EVENTS; k++) begin
      if (sel == SEL_W'(k + 1)) hit = evt_q[k];
    end
  end

  assign inc       = hit & ~inhibit & ~debug;
  assign ovf_pulse = inc & ~cnt_we & (&count);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
      sel   <= '0;
    end else begin
      if (cnt_we)   count <= cnt_wdata;
      else if (inc) count <= count + 1'b1;
      if (sel_we)   sel <= sel_wdata;
    end
  end

endmodule

// File: rtl/hpm_counter_bank.sv
// Bank of programmable HPM counters behind an SRAM-like CSR port.
// Define HPM_OVF_IRQ_EN to build the sticky overflow flags and the overflow interrupt.
module hpm_counter_bank
  import hpm_counter_bank_pkg::*;
#(
  parameter int unsigned NUM_COUNTERS = 8,
  parameter int unsigned NUM_EVENTS   = 32,
  parameter int unsigned CNT_WIDTH    = 48,
  parameter int unsigned XLEN         = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  debug_mode_i,
  input  logic [NUM_EVENTS-1:0] events_i,
  input  logic [5:0]            addr_i,
  input  logic                  we_i,
  input  logic [XLEN-1:0]       data_i,
  output logic [XLEN-1:0]       data_o,
  output logic                  ovf_irq_o
);

  localparam int unsigned SEL_W = $clog2(NUM_EVENTS + 1);

  logic [NUM_EVENTS-1:0]   evt_q;
  logic [NUM_COUNTERS-1:0] inhibit_q;
  logic [NUM_COUNTERS-1:0] ovf_pulse;
  logic [CNT_WIDTH-1:0]    count [NUM_COUNTERS];
  logic [SEL_W-1:0]        sel   [NUM_COUNTERS];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      evt_q     <= '0;
      inhibit_q <= '0;
    end else begin
      evt_q <= events_i;
      if (we_i && addr_i == HPM_INH_ADDR) inhibit_q <= data_i[NUM_COUNTERS-1:0];
    end
  end

  for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_cnt
    hpm_counter #(
      .NUM_EVENTS (NUM_EVENTS),
      .CNT_WIDTH  (CNT_WIDTH),
      .SEL_W      (SEL_W)
    ) u_cnt (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .evt_q     (evt_q),
      .inhibit   (inhibit_q[i]),
      .debug     (debug_mode_i),
      .cnt_we    (we_i && addr_i == 6'(HPM_CNT_BASE + i)),
      .sel_we    (we_i && addr_i == 6'(HPM_SEL_BASE + i)),
      .cnt_wdata (data_i[CNT_WIDTH-1:0]),
      .sel_wdata (data_i[SEL_W-1:0]),
      .count     (count[i]),
      .sel       (sel[i]),
      .ovf_pulse (ovf_pulse[i])
    );
  end

`ifdef HPM_OVF_IRQ_EN
  logic [NUM_COUNTERS-1:0] ovf_q;
  logic [NUM_COUNTERS-1:0] ovf_clr;
  logic                    irq_q;
  logic                    unused_bits;

  // Set wins over a same-cycle write-1-to-clear, so no wrap is ever lost.
  assign ovf_clr = (we_i && addr_i == HPM_OVF_ADDR) ? data_i[NUM_COUNTERS-1:0] : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_q <= '0;
      irq_q <= 1'b0;
    end else begin
      ovf_q <= (ovf_q & ~ovf_clr) | ovf_pulse;
      irq_q <= |ovf_q;
    end
  end

  assign ovf_irq_o   = irq_q;
  assign unused_bits = ^data_i;
`else
  logic unused_bits;

  assign ovf_irq_o   = 1'b0;
  assign unused_bits = ^{data_i, ovf_pulse};
`endif

  always_comb begin
    data_o = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (addr_i == 6'(HPM_CNT_BASE + i)) data_o = XLEN'(count[i]);
      if (addr_i == 6'(HPM_SEL_BASE + i)) data_o = XLEN'(sel[i]);
    end
    if (addr_i == HPM_INH_ADDR) data_o = XLEN'(inhibit_q);
`ifdef HPM_OVF_IRQ_EN
    if (addr_i == HPM_OVF_ADDR) data_o = XLEN'(ovf_q);
`endif
  end

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Randomised self-checking bench for hpm_counter_bank against a register-level reference model.
// Expectations for the overflow status and interrupt follow HPM_OVF_IRQ_EN.
module tb_hpm_counter_bank;

  localparam int NC = 8;
  localparam int NE = 32;
  localparam int CW = 48;
  localparam int XL = 64;
  localparam int SW = 6;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          debug_mode_i;
  logic [NE-1:0] events_i;
  logic [5:0]    addr_i;
  logic          we_i;
  logic [XL-1:0] data_i;
  logic [XL-1:0] data_o;
  logic          ovf_irq_o;

  always #5 clk_i = ~clk_i;

  hpm_counter_bank dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .debug_mode_i (debug_mode_i),
    .events_i     (events_i),
    .addr_i       (addr_i),
    .we_i         (we_i),
    .data_i       (data_i),
    .data_o       (data_o),
    .ovf_irq_o    (ovf_irq_o)
  );

  // Reference model state, described as software-visible registers.
  logic [CW-1:0] mCnt [NC];
  logic [SW-1:0] mSel [NC];
  logic [NC-1:0] mInh;
  logic [NC-1:0] mOvf;
  logic          mIrq;
  logic [NE-1:0] mEvtQ;

  int checks   = 0;
  int failures = 0;
  logic [XL-1:0] lastRead;
  logic          lastIrq;

  task automatic checkOutput(input string tag, input logic [XL-1:0] got, input logic [XL-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [XL-1:0] modelRead(input logic [5:0] a);
    int ai;
    ai = int'(a);
    if (ai < NC) return XL'(mCnt[ai]);
    if (ai >= 32 && ai < 32 + NC) return XL'(mSel[ai - 32]);
    if (ai == 63) return XL'(mInh);
`ifdef HPM_OVF_IRQ_EN
    if (ai == 62) return XL'(mOvf);
`endif
    return '0;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NC; i++) begin
      mCnt[i] = '0;
      mSel[i] = '0;
    end
    mInh  = '0;
    mOvf  = '0;
    mIrq  = 1'b0;
    mEvtQ = '0;
  endtask

  // One rising edge worth of register updates, using the inputs currently driven.
  task automatic modelClock();
    logic [NC-1:0] setMask;
    logic [NC-1:0] clrMask;
    int s;
    bit hit;
    setMask = '0;
    for (int i = 0; i < NC; i++) begin
      s   = int'(mSel[i]);
      hit = (s >= 1 && s <= NE) ? mEvtQ[s-1] : 1'b0;
      hit = hit && !mInh[i] && !debug_mode_i;
      if (we_i && int'(addr_i) == i) mCnt[i] = data_i[CW-1:0];
      else if (hit) begin
        if (mCnt[i] == {CW{1'b1}}) setMask[i] = 1'b1;
        mCnt[i] = mCnt[i] + 1'b1;
      end
      if (we_i && int'(addr_i) == 32 + i) mSel[i] = data_i[SW-1:0];
    end
    if (we_i && addr_i == 6'd63) mInh = data_i[NC-1:0];
`ifdef HPM_OVF_IRQ_EN
    mIrq = |mOvf;
`endif
    clrMask = (we_i && addr_i == 6'd62) ? data_i[NC-1:0] : '0;
    mOvf  = (mOvf & ~clrMask) | setMask;
    mEvtQ = events_i;
  endtask

  // Drive one cycle, check the combinational read and interrupt mid-cycle, then clock the model.
  task automatic applyStimulus(input logic [5:0] a, input logic w, input logic [XL-1:0] d,
                               input logic [NE-1:0] ev, input logic dbg);
    addr_i       = a;
    we_i         = w;
    data_i       = d;
    events_i     = ev;
    debug_mode_i = dbg;
    @(negedge clk_i);
    lastRead = data_o;
    lastIrq  = ovf_irq_o;
    checkOutput($sformatf("read_a%0d", a), data_o, modelRead(a));
    checkOutput("irq", XL'(ovf_irq_o), XL'(mIrq));
    @(posedge clk_i);
    modelClock();
    #1;
  endtask

  task automatic writeReg(input logic [5:0] a, input logic [XL-1:0] d);
    applyStimulus(a, 1'b1, d, '0, 1'b0);
  endtask

  // Assert reset between edges and confirm state clears without waiting for a clock.
  task automatic doReset();
    rst_i = 1'b1;
    #2;
    checkOutput("rst_async_data", data_o, '0);
    checkOutput("rst_async_irq", XL'(ovf_irq_o), '0);
    modelReset();
    @(posedge clk_i);
    #1;
    events_i = '0;
    we_i     = 1'b0;
    rst_i    = 1'b0;
  endtask

  logic [XL-1:0] rd [6];
  logic [XL-1:0] expOvf;
  logic          expIrq;
  logic [NE-1:0] ev2;
  logic [NE-1:0] ev0;

  initial begin
    rst_i        = 1'b1;
    debug_mode_i = 1'b0;
    events_i     = '0;
    addr_i       = '0;
    we_i         = 1'b0;
    data_i       = '0;
    modelReset();
    ev2 = NE'(4);
    ev0 = NE'(1);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Reset state across the whole address space.
    for (int a = 0; a < 64; a++) applyStimulus(6'(a), 1'b0, '0, '0, 1'b0);

    // Five isolated pulses on event 3.
    writeReg(6'd32, 64'd3);
    for (int p = 0; p < 5; p++) begin
      applyStimulus(6'd0, 1'b0, '0, ev2, 1'b0);
      applyStimulus(6'd0, 1'b0, '0, '0, 1'b0);
    end
    applyStimulus(6'd0, 1'b0, '0, '0, 1'b0);
    checkOutput("cnt0_eq5", lastRead, 64'd5);
    applyStimulus(6'd1, 1'b0, '0, '0, 1'b0);
    checkOutput("cnt1_idle", lastRead, 64'd0);

    // Wrap of counter 2 and overflow flag.
    writeReg(6'd2, 64'hFFFF_FFFF_FFFE);
    writeReg(6'd34, 64'd1);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(6'd2, 1'b0, '0, (c < 3) ? ev0 : '0, 1'b0);
      rd[c] = lastRead;
    end
    checkOutput("wrap_max", rd[2], 64'hFFFF_FFFF_FFFF);
    checkOutput("wrap_zero", rd[3], 64'd0);
    checkOutput("wrap_one", rd[4], 64'd1);
`ifdef HPM_OVF_IRQ_EN
    expOvf = 64'd4;
    expIrq = 1'b1;
`else
    expOvf = 64'd0;
    expIrq = 1'b0;
`endif
    applyStimulus(6'd62, 1'b0, '0, '0, 1'b0);
    checkOutput("ovf_status", lastRead, expOvf);
    checkOutput("ovf_irq_set", XL'(lastIrq), XL'(expIrq));
    writeReg(6'd62, 64'd4);
    applyStimulus(6'd62, 1'b0, '0, '0, 1'b0);
    checkOutput("ovf_cleared", lastRead, 64'd0);
    applyStimulus(6'd62, 1'b0, '0, '0, 1'b0);
    checkOutput("ovf_irq_clear", XL'(lastIrq), 64'd0);

    // Write beats a same-cycle increment.
    for (int c = 0; c < 4; c++) applyStimulus(6'd0, 1'b0, '0, ev2, 1'b0);
    applyStimulus(6'd0, 1'b1, 64'd100, ev2, 1'b0);
    applyStimulus(6'd0, 1'b0, '0, ev2, 1'b0);
    checkOutput("wr_prio_t1", lastRead, 64'd100);
    applyStimulus(6'd0, 1'b0, '0, ev2, 1'b0);
    checkOutput("wr_prio_t2", lastRead, 64'd101);

    // Inhibit and debug freeze.
    writeReg(6'd33, 64'd3);
    writeReg(6'd63, 64'd1);
    writeReg(6'd0, 64'd7);
    for (int c = 0; c < 4; c++) applyStimulus(6'd1, 1'b0, '0, ev2, 1'b0);
    applyStimulus(6'd0, 1'b0, '0, ev2, 1'b0);
    checkOutput("inhibit_frozen", lastRead, 64'd7);
    writeReg(6'd63, 64'd0);
    applyStimulus(6'd0, 1'b1, 64'd9, ev2, 1'b1);
    for (int c = 0; c < 4; c++) applyStimulus(6'd0, 1'b0, '0, ev2, 1'b1);
    checkOutput("debug_frozen", lastRead, 64'd9);

    // Out-of-range and zero selectors.
    writeReg(6'd32, 64'd33);
    writeReg(6'd0, 64'd5);
    for (int c = 0; c < 4; c++) applyStimulus(6'd0, 1'b0, '0, '1, 1'b0);
    checkOutput("sel_over", lastRead, 64'd5);
    writeReg(6'd32, 64'd0);
    for (int c = 0; c < 4; c++) applyStimulus(6'd0, 1'b0, '0, '1, 1'b0);
    checkOutput("sel_zero", lastRead, 64'd5);

    // Reset in the middle of counting.
    writeReg(6'd32, 64'd3);
    for (int c = 0; c < 3; c++) applyStimulus(6'd0, 1'b0, '0, ev2, 1'b0);
    doReset();
    for (int c = 0; c < 3; c++) applyStimulus(6'd0, 1'b0, '0, '0, 1'b0);
    checkOutput("post_rst_cnt0", lastRead, 64'd0);
    applyStimulus(6'd32, 1'b0, '0, '0, 1'b0);
    checkOutput("post_rst_sel0", lastRead, 64'd0);

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      logic [5:0]    a;
      logic          w;
      logic [XL-1:0] d;
      logic [NE-1:0] ev;
      logic          dbg;
      int            pick;
      if ($urandom_range(0, 399) == 0) doReset();
      pick = int'($urandom_range(0, 9));
      if (pick < 4)       a = 6'($urandom_range(0, NC + 1));
      else if (pick < 7)  a = 6'($urandom_range(32, 32 + NC + 1));
      else if (pick == 7) a = 6'd62;
      else if (pick == 8) a = 6'd63;
      else                a = 6'($urandom_range(0, 63));
      w = ($urandom_range(0, 3) == 0);
      if (a >= 6'd32 && a < 6'd62) d = XL'($urandom_range(0, 40)) | ({$urandom, $urandom} & 64'hFFFF_FF00_0000_0000);
      else if (a == 6'd63)         d = ($urandom_range(0, 2) == 0) ? {$urandom, $urandom} : 64'd0;
      else if ($urandom_range(0, 1) == 0) d = {$urandom, $urandom};
      else d = {16'hABCD, 48'hFFFF_FFFF_FFF0} + XL'($urandom_range(0, 15));
      ev  = ($urandom_range(0, 1) == 0) ? NE'($urandom) : NE'($urandom & $urandom & $urandom);
      dbg = ($urandom_range(0, 9) == 0);
      applyStimulus(a, w, d, ev, dbg);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
